data_mem_responder: RTL and testbench

- Responder end of the memory-control interface: consumes memRead / memWrite / mode as decoded from the instruction and performs the access on a word-organised synchronous data RAM held inside the block.
- Handles byte-lane selection and sign/zero extension on loads, and read-modify-write for sub-word stores.
- Reports misaligned accesses.
- Stalls the pipeline while an access is in flight.

---
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Responder side of the memory-control interface: executes word/half/byte loads and
// stores against an internal synchronous word RAM, with lane extraction and RMW merging.
module data_mem_responder #(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  mode,
    input  logic        loadUnsigned,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        done,
    output logic        stall,
    output logic        misaligned
);
    // Access-size encodings shared with the instruction decoder.
    localparam logic [1:0] MEM_WORD = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_BYTE = 2'd2;

    typedef enum logic [2:0] {IDLE, FAULT, RD, RDONE, WR, RMW_RD, RMW_WR} state_t;

    state_t state, state_next;

    logic [31:0]          mem [2**ADDR_BITS];
    logic [ADDR_BITS-1:0] idx_q;
    logic [1:0]           lane_q;
    logic [1:0]           mode_q;
    logic                 unsigned_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rd_word;
    logic [31:0]          read_q;
    logic [31:0]          load_val;
    logic [31:0]          merged;
    logic [7:0]           byte_v;
    logic [15:0]          half_v;
    logic                 request;
    logic                 fault_now;
    logic                 unused_addr_bits;

    assign request = memRead | memWrite;
    // Upper address bits are deliberately dropped so the address space wraps.
    assign unused_addr_bits = ^address[31:ADDR_BITS+2];

    always_comb begin
        case (mode)
            MEM_HALF: fault_now = address[0];
            MEM_BYTE: fault_now = 1'b0;
            default:  fault_now = |address[1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        misaligned = 1'b0;
        readData   = read_q;
        case (state)
            IDLE: begin
                if (request) begin
                    if (fault_now)              state_next = FAULT;
                    else if (memWrite)          state_next = (mode == MEM_HALF || mode == MEM_BYTE) ? RMW_RD : WR;
                    else                        state_next = RD;
                end
            end
            FAULT: begin
                done       = 1'b1;
                misaligned = 1'b1;
                readData   = '0;
                state_next = IDLE;
            end
            RD:     state_next = RDONE;
            RDONE: begin
                done       = 1'b1;
                readData   = load_val;
                state_next = IDLE;
            end
            WR: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            RMW_RD: state_next = RMW_WR;
            RMW_WR: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign stall = (request && state == IDLE) || (state != IDLE && !done);

    always_comb begin
        byte_v   = rd_word[{lane_q, 3'b000} +: 8];
        half_v   = rd_word[{lane_q[1], 4'b0000} +: 16];
        load_val = rd_word;
        merged   = rd_word;
        case (mode_q)
            MEM_BYTE: begin
                load_val = unsigned_q ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
                merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            MEM_HALF: begin
                load_val = unsigned_q ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
                merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_val = rd_word;
                merged   = wdata_q;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_q <= '0;
        end else begin
            if (done) read_q <= readData;
            if (state == IDLE && request) begin
                idx_q      <= address[ADDR_BITS+1:2];
                lane_q     <= address[1:0];
                mode_q     <= mode;
                unsigned_q <= loadUnsigned;
                wdata_q    <= writeData;
            end
        end
    end

    // NOTE: the RAM array is never reset; reset only suppresses a write that has not yet happened.
    always_ff @(posedge clk) begin
        if (state == RD || state == RMW_RD) rd_word <= mem[idx_q];
        if (!reset && state == WR)          mem[idx_q] <= wdata_q;
        if (!reset && state == RMW_WR)      mem[idx_q] <= merged;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: expected results queued at issue, checked on done.
module tb_data_mem_responder;
    localparam int         ADDR_BITS = 10;
    localparam logic [1:0] MEM_WORD  = 2'd0;
    localparam logic [1:0] MEM_HALF  = 2'd1;
    localparam logic [1:0] MEM_BYTE  = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead, memWrite, loadUnsigned;
    logic [1:0]  mode;
    logic [31:0] address, writeData, readData;
    logic        done, stall, misaligned;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        mis;
        int          lat;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];

    data_mem_responder #(.ADDR_BITS(ADDR_BITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .mode         (mode),
        .loadUnsigned (loadUnsigned),
        .address      (address),
        .writeData    (writeData),
        .readData     (readData),
        .done         (done),
        .stall        (stall),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue one access, scramble the inputs after acceptance, and compare when done pulses.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] md,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdat,
                          input logic [31:0] exp_data, input logic exp_mis, input int exp_lat,
                          input bit chk_data);
        exp_t e;
        int   lat;
        int   stalls;
        sb.push_back('{tag, exp_data, exp_mis, exp_lat, chk_data});
        @(negedge clk);
        memRead = rd; memWrite = wr; mode = md; loadUnsigned = uns;
        address = addr; writeData = wdat;
        #1 stalls = stall ? 1 : 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            stalls += stall ? 1 : 0;
            if (!done) begin
                address      = $urandom;
                writeData    = $urandom;
                loadUnsigned = ~uns;
                mode         = 2'($urandom);
            end
        end while (!done && lat < 6);
        e = sb.pop_front();
        check({e.tag, " done"}, 32'(done), 32'd1);
        check({e.tag, " latency"}, lat, e.lat);
        check({e.tag, " stall cycles"}, stalls, e.lat);
        check({e.tag, " misaligned"}, 32'(misaligned), 32'(e.mis));
        if (e.chk_data) check({e.tag, " readData"}, readData, e.data);
        memRead = 1'b0; memWrite = 1'b0;
    endtask

    task automatic store(input string tag, input logic [1:0] md, input logic [31:0] addr, input logic [31:0] wdat);
        access(tag, 1'b0, 1'b1, md, 1'b0, addr, wdat, 32'h0, 1'b0, (md == MEM_WORD) ? 1 : 2, 1'b0);
    endtask

    task automatic load(input string tag, input logic [1:0] md, input logic uns, input logic [31:0] addr, input logic [31:0] exp_data);
        access(tag, 1'b1, 1'b0, md, uns, addr, 32'h0, exp_data, 1'b0, 2, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; mode = MEM_WORD;
        loadUnsigned = 1'b0; address = '0; writeData = '0;
        repeat (2) @(negedge clk);
        check("reset readData", readData, 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset stall", 32'(stall), 32'h0);
        check("reset misaligned", 32'(misaligned), 32'h0);
        reset = 1'b0;

        store("st w 0x10", MEM_WORD, 32'h10, 32'hDEADBEEF);
        load ("ld w 0x10", MEM_WORD, 1'b0, 32'h10, 32'hDEADBEEF);

        store("st w 0x20", MEM_WORD, 32'h20, 32'h11223344);
        store("st b 0x22", MEM_BYTE, 32'h22, 32'hFFFFFF80);
        load ("ld w 0x20", MEM_WORD, 1'b0, 32'h20, 32'h11803344);
        load ("ld b 0x22 s", MEM_BYTE, 1'b0, 32'h22, 32'hFFFFFF80);
        load ("ld b 0x22 u", MEM_BYTE, 1'b1, 32'h22, 32'h00000080);
        load ("ld b 0x23 u", MEM_BYTE, 1'b1, 32'h23, 32'h00000011);
        load ("ld b 0x20 s", MEM_BYTE, 1'b0, 32'h20, 32'h00000044);

        store("st w 0x30", MEM_WORD, 32'h30, 32'h00000000);
        store("st h 0x32", MEM_HALF, 32'h32, 32'h1234BEEF);
        load ("ld w 0x30", MEM_WORD, 1'b0, 32'h30, 32'hBEEF0000);
        load ("ld h 0x32 s", MEM_HALF, 1'b0, 32'h32, 32'hFFFFBEEF);
        load ("ld h 0x32 u", MEM_HALF, 1'b1, 32'h32, 32'h0000BEEF);
        load ("ld h 0x30 s", MEM_HALF, 1'b0, 32'h30, 32'h00000000);

        store("st w 0x40", MEM_WORD, 32'h40, 32'hCAFEF00D);
        access("ld w 0x41 fault", 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        access("st h 0x43 fault", 1'b0, 1'b1, MEM_HALF, 1'b0, 32'h43, 32'h0000FFFF, 32'h0, 1'b1, 1, 1'b1);
        load ("ld w 0x40 after faults", MEM_WORD, 1'b0, 32'h40, 32'hCAFEF00D);
        load ("ld b 0x41 u", MEM_BYTE, 1'b1, 32'h41, 32'h000000F0);

        access("rd+wr w 0x50", 1'b1, 1'b1, MEM_WORD, 1'b0, 32'h50, 32'h5, 32'h0, 1'b0, 1, 1'b0);
        load ("ld w 0x50", MEM_WORD, 1'b0, 32'h50, 32'h00000005);
        store("st w 0x50 alias", MEM_WORD, 32'h50 + (32'd4 << ADDR_BITS), 32'h00000077);
        load ("ld w 0x50 after alias", MEM_WORD, 1'b0, 32'h50, 32'h00000077);

        store("st w 0x60", MEM_WORD, 32'h60, 32'hAABBCCDD);
        @(negedge clk);
        memWrite = 1'b1; mode = MEM_BYTE; address = 32'h60; writeData = 32'h11;
        @(negedge clk);
        check("rmw_rd stall", 32'(stall), 32'h1);
        reset = 1'b1; memWrite = 1'b0;
        @(negedge clk);
        check("abort readData", readData, 32'h0);
        check("abort done", 32'(done), 32'h0);
        check("abort stall", 32'(stall), 32'h0);
        check("abort misaligned", 32'(misaligned), 32'h0);
        reset = 1'b0;
        load ("ld w 0x60 after abort", MEM_WORD, 1'b0, 32'h60, 32'hAABBCCDD);

        check("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
